// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the DDS tuning word between start/stop with
// per-word dwell, in single, sawtooth, triangle or constant-tone patterns.
module dds_sweep_ctrl #(
  parameter int N  = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_start,
  input  logic [N-1:0]  cfg_stop,
  input  logic [N-1:0]  cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          abort,
  output logic [N-1:0]  fcw,
  output logic          fcw_upd,
  output logic          eo,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t state_q, state_d;

  logic [N-1:0]  sh_start_q, sh_stop_q, sh_step_q;
  logic [DW-1:0] sh_dwell_q;
  logic [1:0]    sh_mode_q;
  logic          loaded_q;

  // Active copy taken at start, so a config accepted in the same cycle cannot
  // alter the sweep that the start launched.
  logic [N-1:0]  a_start_q, a_stop_q, a_step_q;
  logic [N-1:0]  a_start_d, a_stop_d, a_step_d;
  logic [DW-1:0] a_dwell_q, a_dwell_d;
  logic [1:0]    a_mode_q, a_mode_d;

  logic [N-1:0]  fcw_q, fcw_d;
  logic          upd_q, upd_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          rev_q, rev_d;

  logic          up0, dir_up, degen, at_end, expire, single, go;
  logic [N-1:0]  tgt;

  function automatic logic [N-1:0] step_word(input logic [N-1:0] cur,
                                              input logic [N-1:0] stp,
                                              input logic [N-1:0] lim,
                                              input logic         up);
    logic [N:0] s;
    if (up) begin
      s = {1'b0, cur} + {1'b0, stp};
      step_word = (s[N] || (s[N-1:0] >= lim)) ? lim : s[N-1:0];
    end else begin
      s = {1'b0, cur} - {1'b0, stp};
      step_word = (s[N] || (s[N-1:0] <= lim)) ? lim : s[N-1:0];
    end
  endfunction

  // rev_q=1 means the current segment heads back toward the start word.
  assign up0    = (a_start_q <= a_stop_q);
  assign dir_up = up0 ^ rev_q;
  assign tgt    = rev_q ? a_start_q : a_stop_q;
  assign degen  = (a_step_q == '0) || (a_start_q == a_stop_q);
  assign at_end = (fcw_q == tgt);
  assign expire = (cnt_q == '0);
  assign single = (a_mode_q != 2'd1) && (a_mode_q != 2'd2);
  assign go     = (state_q != S_SWEEP) && start && loaded_q && !abort;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = go ? S_SWEEP : S_IDLE;
        S_DONE:  state_d = go ? S_SWEEP : S_IDLE;
        S_SWEEP: if (!degen && expire && at_end && single) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state_q != S_SWEEP);
    busy      = (state_q == S_SWEEP);
    eo        = (state_q == S_SWEEP);
    done      = (state_q == S_DONE);
    fcw       = fcw_q;
    fcw_upd   = upd_q;
  end

  always_comb begin
    fcw_d     = fcw_q;
    upd_d     = 1'b0;
    cnt_d     = cnt_q;
    rev_d     = rev_q;
    a_start_d = a_start_q;
    a_stop_d  = a_stop_q;
    a_step_d  = a_step_q;
    a_dwell_d = a_dwell_q;
    a_mode_d  = a_mode_q;
    if (abort) begin
      fcw_d = '0;
      rev_d = 1'b0;
    end else if (go) begin
      a_start_d = sh_start_q;
      a_stop_d  = sh_stop_q;
      a_step_d  = sh_step_q;
      a_dwell_d = sh_dwell_q;
      a_mode_d  = sh_mode_q;
      fcw_d     = sh_start_q;
      upd_d     = 1'b1;
      cnt_d     = sh_dwell_q;
      rev_d     = 1'b0;
    end else if (state_q == S_SWEEP && !degen) begin
      if (!expire) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!at_end) begin
        fcw_d = step_word(fcw_q, a_step_q, tgt, dir_up);
        upd_d = 1'b1;
        cnt_d = a_dwell_q;
      end else if (a_mode_q == 2'd1) begin
        fcw_d = a_start_q;
        upd_d = 1'b1;
        cnt_d = a_dwell_q;
      end else if (a_mode_q == 2'd2) begin
        // Turn around and take the first step of the new segment immediately.
        rev_d = !rev_q;
        fcw_d = step_word(fcw_q, a_step_q, rev_q ? a_stop_q : a_start_q, !dir_up);
        upd_d = 1'b1;
        cnt_d = a_dwell_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcw_q     <= '0;
      upd_q     <= 1'b0;
      cnt_q     <= '0;
      rev_q     <= 1'b0;
      a_start_q <= '0;
      a_stop_q  <= '0;
      a_step_q  <= '0;
      a_dwell_q <= '0;
      a_mode_q  <= '0;
    end else begin
      fcw_q     <= fcw_d;
      upd_q     <= upd_d;
      cnt_q     <= cnt_d;
      rev_q     <= rev_d;
      a_start_q <= a_start_d;
      a_stop_q  <= a_stop_d;
      a_step_q  <= a_step_d;
      a_dwell_q <= a_dwell_d;
      a_mode_q  <= a_mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
      sh_dwell_q <= '0;
      sh_mode_q  <= '0;
      loaded_q   <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      sh_start_q <= cfg_start;
      sh_stop_q  <= cfg_stop;
      sh_step_q  <= cfg_step;
      sh_dwell_q <= cfg_dwell;
      sh_mode_q  <= cfg_mode;
      loaded_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed vector bench for dds_sweep_ctrl: a per-cycle table for the single-shot
// sweep, abort and reset paths, plus hand sequences for sawtooth, triangle and tone.
module tb_dds_sweep_ctrl;
  localparam int N  = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_ready, start, abort;
  logic [N-1:0]  cfg_start, cfg_stop, cfg_step, fcw;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic          fcw_upd, eo, busy, done;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic [N-1:0]  s, p, st;
    logic [DW-1:0] d;
    logic [1:0]    m;
  } cfg_t;

  typedef struct {
    string        nm;
    logic         r, cv, st, ab;
    int           ci;
    logic [N-1:0] fcw;
    logic         upd, eo, busy, done, rdy;
  } vec_t;

  cfg_t cfgs [5];
  vec_t tbl [$];

  dds_sweep_ctrl #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .start(start), .abort(abort),
    .fcw(fcw), .fcw_upd(fcw_upd), .eo(eo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic r, logic cv, int ci, logic st, logic ab,
                              logic [N-1:0] f, logic u, logic e, logic b, logic d, logic rd);
    vec_t v;
    v.nm = nm; v.r = r; v.cv = cv; v.ci = ci; v.st = st; v.ab = ab;
    v.fcw = f; v.upd = u; v.eo = e; v.busy = b; v.done = d; v.rdy = rd;
    return v;
  endfunction

  // Expected outputs after the edge leave the block idle.
  function automatic vec_t id(string nm, logic r, logic cv, int ci, logic st, logic ab,
                              logic [N-1:0] f);
    return mk(nm, r, cv, ci, st, ab, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Expected outputs after the edge show a sweep in progress.
  function automatic vec_t bz(string nm, logic cv, int ci, logic st, logic [N-1:0] f, logic u);
    return mk(nm, 1'b0, cv, ci, st, 1'b0, f, u, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic apply(input vec_t v);
    cfg_t c;
    c         = cfgs[v.ci];
    rst       = v.r;
    cfg_valid = v.cv;
    start     = v.st;
    abort     = v.ab;
    cfg_start = c.s;
    cfg_stop  = c.p;
    cfg_step  = c.st;
    cfg_dwell = c.d;
    cfg_mode  = c.m;
    @(posedge clk);
    #1;
    nvec++;
    if ({fcw, fcw_upd, eo, busy, done, cfg_ready} !== {v.fcw, v.upd, v.eo, v.busy, v.done, v.rdy}) begin
      nbad++;
      $display("FAIL %s: got fcw=%0d upd=%b eo=%b busy=%b done=%b rdy=%b, want fcw=%0d upd=%b eo=%b busy=%b done=%b rdy=%b",
               v.nm, fcw, fcw_upd, eo, busy, done, cfg_ready,
               v.fcw, v.upd, v.eo, v.busy, v.done, v.rdy);
    end
  endtask

  initial begin
    logic [N-1:0] saw [3];
    logic [N-1:0] tri_w [9];

    cfgs[0] = '{s: 14'd100,   p: 14'd400,   st: 14'd100, d: 16'd2, m: 2'd0};
    cfgs[1] = '{s: 14'd7,     p: 14'd9,     st: 14'd1,   d: 16'd0, m: 2'd0};
    cfgs[2] = '{s: 14'd16000, p: 14'd16383, st: 14'd300, d: 16'd0, m: 2'd1};
    cfgs[3] = '{s: 14'd1000,  p: 14'd400,   st: 14'd250, d: 16'd1, m: 2'd2};
    cfgs[4] = '{s: 14'd500,   p: 14'd500,   st: 14'd10,  d: 16'd0, m: 2'd0};

    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;

    tbl.push_back(id("reset",      1, 0, 0, 0, 0, 0));
    tbl.push_back(id("nocfg_st0",  0, 0, 0, 1, 0, 0));
    tbl.push_back(id("nocfg_st1",  0, 0, 0, 1, 0, 0));
    tbl.push_back(id("cfgA",       0, 1, 0, 0, 0, 0));
    tbl.push_back(bz("w100a", 0, 0, 1, 100, 1));
    tbl.push_back(bz("w100b", 0, 0, 1, 100, 0));
    tbl.push_back(bz("w100c", 0, 0, 0, 100, 0));
    tbl.push_back(bz("w200a", 1, 1, 0, 200, 1));
    tbl.push_back(bz("w200b", 1, 1, 0, 200, 0));
    tbl.push_back(bz("w200c", 1, 1, 0, 200, 0));
    tbl.push_back(bz("w300a", 1, 1, 0, 300, 1));
    tbl.push_back(bz("w300b", 1, 1, 0, 300, 0));
    tbl.push_back(bz("w300c", 0, 0, 0, 300, 0));
    tbl.push_back(bz("w400a", 0, 0, 0, 400, 1));
    tbl.push_back(bz("w400b", 0, 0, 0, 400, 0));
    tbl.push_back(bz("w400c", 0, 0, 0, 400, 0));
    tbl.push_back(mk("done", 0, 0, 0, 0, 0, 400, 0, 0, 0, 1, 1));
    tbl.push_back(id("idle_after", 0, 0, 0, 0, 0, 400));
    tbl.push_back(bz("rep100a", 0, 0, 1, 100, 1));
    tbl.push_back(bz("rep100b", 0, 0, 0, 100, 0));
    tbl.push_back(bz("rep100c", 0, 0, 0, 100, 0));
    tbl.push_back(bz("rep200",  0, 0, 0, 200, 1));
    tbl.push_back(id("abort_st", 0, 0, 0, 1, 1, 0));
    tbl.push_back(bz("rep2_100a", 0, 0, 1, 100, 1));
    tbl.push_back(bz("rep2_100b", 0, 0, 0, 100, 0));
    tbl.push_back(bz("rep2_100c", 0, 0, 0, 100, 0));
    tbl.push_back(bz("rep2_200",  0, 0, 0, 200, 1));
    tbl.push_back(id("rst_mid",     1, 0, 0, 1, 0, 0));
    tbl.push_back(id("post_rst_s0", 0, 0, 0, 1, 0, 0));
    tbl.push_back(id("post_rst_s1", 0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Sawtooth near full scale: clamps to 16383, never wraps.
    saw[0] = 14'd16000; saw[1] = 14'd16300; saw[2] = 14'd16383;
    apply(id("cfg_saw", 0, 1, 2, 0, 0, 0));
    apply(bz("saw_go", 0, 2, 1, 16000, 1));
    for (int i = 0; i < 9; i++) apply(bz("saw_step", 0, 2, 0, saw[(i + 1) % 3], 1));
    apply(id("saw_abort", 0, 0, 2, 0, 1, 0));

    // Downward triangle, each word held two cycles.
    tri_w[0] = 14'd1000; tri_w[1] = 14'd750; tri_w[2] = 14'd500;
    tri_w[3] = 14'd400;  tri_w[4] = 14'd650; tri_w[5] = 14'd900;
    tri_w[6] = 14'd1000; tri_w[7] = 14'd750; tri_w[8] = 14'd500;
    apply(id("cfg_tri", 0, 1, 3, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      for (int h = 0; h < 2; h++) begin
        apply(bz("tri_word", 0, 3, (i == 0 && h == 0), tri_w[i], (h == 0)));
      end
    end
    apply(id("tri_abort", 0, 0, 3, 0, 1, 0));

    // Config and start together: the old triangle config runs, the new one waits.
    apply(bz("mix_go",   1, 4, 1, 1000, 1));
    apply(bz("mix_hold", 0, 4, 0, 1000, 0));
    apply(bz("mix_step", 0, 4, 0, 750, 1));
    apply(id("mix_abort", 0, 0, 4, 0, 1, 0));

    // start == stop: constant tone, no further updates, no completion.
    apply(bz("tone_go", 0, 4, 1, 500, 1));
    for (int i = 0; i < 5; i++) apply(bz("tone_hold", 0, 4, 0, 500, 0));
    apply(id("tone_abort", 0, 0, 4, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
